// File: rtl/des128_key_schedule_if.sv
// des128_key_schedule_if
//   Bundles the key-load and round-key handshakes of des128_key_schedule.
//   Ports (slave = schedule block view):
//     key_in, decrypt, key_valid -> key_ready   : key load channel
//     rk_out, rk_round, rk_valid <- rk_ready    : round-key channel
//     busy, done                                : status
//     dbg_state                                 : FSM state (0 = IDLE, 1 = RUN)
//
// Handshake rule for both channels: a transfer happens at a rising clk edge
// where valid and ready are both 1. The producer holds its payload stable
// while valid is 1 and ready is 0. The consumer may change ready at any time.
interface des128_key_schedule_if #(
  parameter int HALF_W = 56
);
  logic [2*HALF_W-1:0] key_in;
  logic                decrypt;
  logic                key_valid;
  logic                key_ready;
  logic [2*HALF_W-1:0] rk_out;
  logic [3:0]          rk_round;
  logic                rk_valid;
  logic                rk_ready;
  logic                busy;
  logic                done;
  logic                dbg_state;

  modport master (
    output key_in, decrypt, key_valid, rk_ready,
    input  key_ready, rk_out, rk_round, rk_valid, busy, done, dbg_state
  );

  modport slave (
    input  key_in, decrypt, key_valid, rk_ready,
    output key_ready, rk_out, rk_round, rk_valid, busy, done, dbg_state
  );
endinterface

// File: rtl/des128_key_schedule.sv
// des128_key_schedule
//   Iterative round-key generator for the 128-bit expanded DES datapath.
//   Takes the post-PC-1 key as two HALF_W halves {C, D}, then emits the 16
//   rotated {C, D} states, one per accepted round-key handshake, in encrypt
//   order (K1..K16) or decrypt order (K16..K1).
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : des128_key_schedule_if.slave (key load, round-key output, status)
module des128_key_schedule #(
  parameter int HALF_W      = 56,
  parameter int ROUNDS      = 16,
  parameter int TOTAL_SHIFT = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  des128_key_schedule_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [3:0]          cnt;       // round keys already handed off
  logic                mode;      // latched decrypt flag
  logic [2*HALF_W-1:0] rk_q;
  logic [3:0]          round_q;
  logic                rk_valid_q;
  logic                key_ready_q;
  logic                busy_q;
  logic                done_q;

  logic [HALF_W-1:0]   c_in, d_in;
  logic [HALF_W-1:0]   c_cur, d_cur;
  logic [HALF_W-1:0]   c_nxt, d_nxt;
  logic                adv_two;

  // Shift schedule indexed by 0-based round: one position for K1, K2, K9,
  // K16, two positions for every other round.
  function automatic logic two_step(input logic [3:0] r);
    return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
  endfunction

  function automatic logic [HALF_W-1:0] rotl_s(input logic [HALF_W-1:0] x,
                                               input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
               : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr_s(input logic [HALF_W-1:0] x,
                                               input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]}
               : {x[0], x[HALF_W-1:1]};
  endfunction

  // Decrypt starts from K16, i.e. the sum of the whole schedule.
  function automatic logic [HALF_W-1:0] rotl_total(input logic [HALF_W-1:0] x);
    return {x[HALF_W-1-TOTAL_SHIFT:0], x[HALF_W-1:HALF_W-TOTAL_SHIFT]};
  endfunction

  assign c_in  = bus.key_in[2*HALF_W-1:HALF_W];
  assign d_in  = bus.key_in[HALF_W-1:0];
  assign c_cur = rk_q[2*HALF_W-1:HALF_W];
  assign d_cur = rk_q[HALF_W-1:0];

  // Encrypt moves Kj -> Kj+1 with the shift of the next round; decrypt undoes
  // the shift of the current round to step Kj -> Kj-1.
  always_comb begin
    adv_two = mode ? two_step(round_q) : two_step(round_q + 4'd1);
    c_nxt   = mode ? rotr_s(c_cur, adv_two) : rotl_s(c_cur, adv_two);
    d_nxt   = mode ? rotr_s(d_cur, adv_two) : rotl_s(d_cur, adv_two);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      mode        <= 1'b0;
      rk_q        <= '0;
      round_q     <= 4'd0;
      rk_valid_q  <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            state       <= RUN;
            cnt         <= 4'd0;
            mode        <= bus.decrypt;
            rk_valid_q  <= 1'b1;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.decrypt) begin
              rk_q    <= {rotl_total(c_in), rotl_total(d_in)};
              round_q <= 4'd15;
            end else begin
              rk_q    <= {rotl_s(c_in, 1'b0), rotl_s(d_in, 1'b0)};
              round_q <= 4'd0;
            end
          end
        end
        RUN: begin
          if (bus.rk_ready) begin
            if (cnt == 4'(ROUNDS - 1)) begin
              // Last key handed off: rk_out/rk_round keep their final values.
              state       <= IDLE;
              rk_valid_q  <= 1'b0;
              key_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              cnt     <= cnt + 4'd1;
              rk_q    <= {c_nxt, d_nxt};
              round_q <= mode ? round_q - 4'd1 : round_q + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rk_out    = rk_q;
  assign bus.rk_round  = round_q;
  assign bus.rk_valid  = rk_valid_q;
  assign bus.key_ready = key_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_des128_key_schedule.sv
module tb_des128_key_schedule;

  logic clk;
  logic rst;

  des128_key_schedule_if #(.HALF_W(56)) bus ();

  des128_key_schedule #(
    .HALF_W(56), .ROUNDS(16), .TOTAL_SHIFT(28)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int sched[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [111:0] last_key;
  logic [3:0]   last_round;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Closed form: subkey r is each half rotated left by the running total of
  // the shift schedule up to and including round r.
  function automatic logic [55:0] rotl_model(input logic [55:0] x, input int n);
    logic [111:0] dbl;
    dbl = {x, x} << n;
    return dbl[111:56];
  endfunction

  function automatic logic [111:0] rand112();
    return {$urandom, $urandom, $urandom, 16'($urandom)};
  endfunction

  function automatic logic [55:0] rand56();
    return {$urandom, 24'($urandom)};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_rk_valid"}, 112'(bus.rk_valid), 112'(0));
    check({tag, "_busy"}, 112'(bus.busy), 112'(0));
    check({tag, "_key_ready"}, 112'(bus.key_ready), 112'(1));
    check({tag, "_done"}, 112'(bus.done), 112'(0));
    check({tag, "_rk_out"}, bus.rk_out, 112'(0));
    check({tag, "_rk_round"}, 112'(bus.rk_round), 112'(0));
  endtask

  // ---------------- driver + scoreboard ----------------
  // Loads one key, then drains the round keys with randomised rk_ready.
  // stall_at: handshake index at which rk_ready is forced low for 5 cycles.
  // abort_at: handshake index at which rst is pulsed instead of continuing.
  // Returns in the done cycle (or right after the abort reset).
  task automatic run_key(input logic [55:0] c, input logic [55:0] d, input bit dec,
                         input int stall_pct, input int stall_at, input int abort_at);
    logic [111:0] exp_q[$];
    logic [3:0]   rnd_q[$];
    int cum[16];
    int acc;
    int pos;
    int cycles;
    int stall_left;
    bit stalled;
    bit rdy;

    acc = 0;
    for (int r = 0; r < 16; r++) begin
      acc += sched[r];
      cum[r] = acc;
    end
    for (int k = 0; k < 16; k++) begin
      int r;
      r = dec ? 15 - k : k;
      exp_q.push_back({rotl_model(c, cum[r]), rotl_model(d, cum[r])});
      rnd_q.push_back(4'(r));
    end

    check("key_ready_idle", 112'(bus.key_ready), 112'(1));
    bus.key_in    = {c, d};
    bus.decrypt   = dec;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
    bus.key_in    = rand112();
    bus.decrypt   = 1'($urandom_range(0, 1));
    check("busy_run", 112'(bus.busy), 112'(1));
    check("key_ready_run", 112'(bus.key_ready), 112'(0));

    pos = 0; cycles = 0; stall_left = 0; stalled = 1'b0;
    while (exp_q.size() > 0 && cycles < 300) begin
      check("rk_valid", 112'(bus.rk_valid), 112'(1));
      check("rk_out", bus.rk_out, exp_q[0]);
      check("rk_round", 112'(bus.rk_round), 112'(rnd_q[0]));
      if (pos == abort_at) begin
        bus.key_valid = 1'b1;
        bus.rk_ready  = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.key_valid = 1'b0;
        check_reset_state("abort");
        return;
      end
      if (pos == stall_at && !stalled) begin
        stalled = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 99) >= stall_pct);
      end
      bus.rk_ready  = rdy;
      // Keys offered during a run must be ignored.
      bus.key_valid = 1'($urandom_range(0, 1));
      bus.key_in    = rand112();
      step();
      cycles++;
      if (rdy) begin
        last_key   = exp_q.pop_front();
        last_round = rnd_q.pop_front();
        pos++;
      end
    end
    bus.key_valid = 1'b0;
    bus.rk_ready  = 1'b0;

    check("schedule_timeout", 112'(exp_q.size()), 112'(0));
    check("done_pulse", 112'(bus.done), 112'(1));
    check("done_rk_valid", 112'(bus.rk_valid), 112'(0));
    check("done_busy", 112'(bus.busy), 112'(0));
    check("done_key_ready", 112'(bus.key_ready), 112'(1));
    if (stall_pct == 0 && stall_at < 0)
      check("throughput_cycles", 112'(cycles), 112'(16));
  endtask

  task automatic after_done(input logic [111:0] hold_key, input logic [3:0] hold_round);
    step();
    check("done_clear", 112'(bus.done), 112'(0));
    check("hold_rk_out", bus.rk_out, hold_key);
    check("hold_rk_round", 112'(bus.rk_round), 112'(hold_round));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.key_in    = {56'h1, 56'h0};
    bus.decrypt   = 1'b0;
    bus.key_valid = 1'b1;   // must be ignored while in reset
    bus.rk_ready  = 1'b0;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    bus.key_valid = 1'b0;
    step();
    check("post_reset_no_accept", 112'(bus.rk_valid), 112'(0));

    // Encrypt, C = 1, D = 0: K16 C ends at bit 28.
    run_key(56'h1, 56'h0, 1'b0, 0, -1, -1);
    after_done({56'h10000000, 56'h0}, 4'd15);

    // Decrypt, same key: last key is K1 with C = 2.
    run_key(56'h1, 56'h0, 1'b1, 0, -1, -1);
    after_done({56'h2, 56'h0}, 4'd0);

    // MSB wrap-around.
    run_key(56'h80_0000_0000_0000, 56'h80_0000_0000_0000, 1'b0, 0, -1, -1);
    after_done({rotl_model(56'h80_0000_0000_0000, 28), rotl_model(56'h80_0000_0000_0000, 28)}, 4'd15);

    // Backpressure at K4 for 5 cycles.
    run_key(rand56(), rand56(), 1'b0, 0, 3, -1);
    after_done(last_key, 4'd15);

    // Reset at K7.
    run_key(rand56(), rand56(), 1'b0, 0, -1, 6);
    step();
    check("abort_no_done", 112'(bus.done), 112'(0));
    check("abort_no_valid", 112'(bus.rk_valid), 112'(0));

    // Back-to-back: second key offered in the done cycle.
    run_key(rand56(), rand56(), 1'b0, 20, -1, -1);
    run_key(rand56(), rand56(), 1'b1, 20, -1, -1);
    after_done(last_key, 4'd0);

    // Randomised keys and directions with random backpressure.
    for (int i = 0; i < 6; i++) begin
      bit dec;
      dec = 1'($urandom_range(0, 1));
      run_key(rand56(), rand56(), dec, 30, -1, -1);
      after_done(last_key, dec ? 4'd0 : 4'd15);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected finished");
    $fatal(1, "global timeout");
  end

endmodule
